// File: rtl/dm_access_stage.sv
// Memory-stage data memory: byte-enabled stores, AdEL/AdES detection, and the
// M->W pipeline register carrying the raw read word and the access address.
module dm_access_stage #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        hold,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  wordmode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] dmout,
  output logic [31:0] ao_w,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HS = 3'd1;
  localparam logic [2:0] WM_HU = 3'd2;
  localparam logic [2:0] WM_BS = 3'd3;
  localparam logic [2:0] WM_BU = 3'd4;

  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  logic [31:0]           mem [DEPTH];
  // Per-word written flag; clearing it stands in for zeroing every word on reset.
  logic [DEPTH-1:0]      written;

  logic [32:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  below_base;
  logic                  above_top;
  logic                  out_of_range;
  logic                  size_ok;
  logic                  misaligned;
  logic [3:0]            be;
  logic [31:0]           lane;
  logic                  access;
  logic                  fault;
  logic                  do_write;
  logic                  do_read;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  unused_offset_lsbs;

  // Address offset from the window base; bit 32 is the borrow (address below base).
  always_comb begin
    offset     = {1'b0, addr} - {1'b0, BASE_ADDR};
    below_base = offset[32];
    above_top  = |offset[31:ADDR_WIDTH+2];
    idx        = offset[ADDR_WIDTH+1:2];
  end

  assign out_of_range       = below_base | above_top;
  assign unused_offset_lsbs = ^offset[1:0];

  // Access size decode: byte enables, replicated lane data, alignment check.
  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    be         = 4'b0000;
    lane       = wdata;
    case (wordmode)
      WM_WD: begin
        be         = 4'b1111;
        misaligned = (addr[1:0] != 2'b00);
        lane       = wdata;
      end
      WM_HS, WM_HU: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
        lane       = {2{wdata[15:0]}};
      end
      WM_BS, WM_BU: begin
        be         = 4'b0001 << addr[1:0];
        misaligned = 1'b0;
        lane       = {4{wdata[7:0]}};
      end
      default: begin
        size_ok    = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
      end
    endcase
  end

  // Fault detection; an unrecognised size never faults.
  always_comb begin
    access    = en & (mem_re | mem_we);
    fault     = access & size_ok & (misaligned | out_of_range);
    exc_valid = fault;
    exc_code  = 5'd0;
    if (fault) begin
      exc_code = mem_we ? CODE_ADES : CODE_ADEL;
    end
  end

  assign do_write = en & mem_we & ~fault & ~hold & (be != 4'b0000);
  assign do_read  = en & mem_re & ~fault;

  // Current word contents (pre-write) and the byte-lane merge for stores.
  always_comb begin
    old_word = written[idx] ? mem[idx] : 32'h0;
    merged   = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[idx] <= merged;
    end
  end

  // Written flags and the M->W pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      written <= '0;
      dmout   <= 32'h0;
      ao_w    <= 32'h0;
    end else begin
      if (do_write) begin
        written[idx] <= 1'b1;
      end
      if (!hold) begin
        ao_w  <= addr;
        dmout <= do_read ? old_word : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_stage.sv
// Directed testbench for dm_access_stage: stores, loads, faults, hold and reset.
module tb_dm_access_stage;

  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HU = 3'd2;
  localparam logic [2:0] WM_BU = 3'd4;
  localparam logic [2:0] WM_BAD = 3'd7;

  logic        clk;
  logic        reset;
  logic        en;
  logic        hold;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  wordmode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dmout;
  logic [31:0] ao_w;
  logic        exc_valid;
  logic [4:0]  exc_code;

  int total;
  int bad;

  dm_access_stage #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .hold      (hold),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .wordmode  (wordmode),
    .addr      (addr),
    .wdata     (wdata),
    .dmout     (dmout),
    .ao_w      (ao_w),
    .exc_valid (exc_valid),
    .exc_code  (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one M-stage access, check the combinational fault outputs, then clock it.
  task automatic op(input string tag, input logic e, input logic re, input logic we,
                    input logic [2:0] wm, input logic [31:0] a, input logic [31:0] d,
                    input logic [4:0] exp_code);
    en       = e;
    mem_re   = re;
    mem_we   = we;
    wordmode = wm;
    addr     = a;
    wdata    = d;
    #1;
    chk({tag, ".exc_valid"}, 32'(exc_valid), 32'(exp_code != 5'd0));
    chk({tag, ".exc_code"}, 32'(exc_code), 32'(exp_code));
    @(posedge clk);
    #1;
  endtask

  task automatic lw(input string tag, input logic [31:0] a, input logic [31:0] exp_data);
    op(tag, 1'b1, 1'b1, 1'b0, WM_WD, a, 32'h0, 5'd0);
    chk({tag, ".dmout"}, dmout, exp_data);
    chk({tag, ".ao_w"}, ao_w, a);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    hold     = 1'b0;
    en       = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    wordmode = WM_WD;
    addr     = 32'h0000_0010;
    wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dmout", dmout, 32'h0);
    chk("reset.ao_w", ao_w, 32'h0);
    reset = 1'b0;

    // Basic word store then load
    op("sw10", 1'b1, 1'b0, 1'b1, WM_WD, 32'h10, 32'h1122_3344, 5'd0);
    chk("sw10.dmout", dmout, 32'h0);
    chk("sw10.ao_w", ao_w, 32'h10);
    lw("lw10a", 32'h10, 32'h1122_3344);

    // Bubble: no exception on misaligned address, no data captured
    op("bubble", 1'b0, 1'b1, 1'b0, WM_WD, 32'h12, 32'h0, 5'd0);
    chk("bubble.dmout", dmout, 32'h0);
    chk("bubble.ao_w", ao_w, 32'h12);

    // Partial stores
    op("sb13", 1'b1, 1'b0, 1'b1, WM_BU, 32'h13, 32'h0000_00AA, 5'd0);
    lw("lw10b", 32'h10, 32'hAA22_3344);
    op("sh12", 1'b1, 1'b0, 1'b1, WM_HU, 32'h12, 32'h0000_BEEF, 5'd0);
    lw("lw10c", 32'h10, 32'hBEEF_3344);
    op("sb10", 1'b1, 1'b0, 1'b1, WM_BU, 32'h24, 32'hFFFF_FF5A, 5'd0);
    lw("lw24", 32'h24, 32'h0000_005A);

    // Misaligned accesses
    op("lw12", 1'b1, 1'b1, 1'b0, WM_WD, 32'h12, 32'h0, 5'd4);
    chk("lw12.dmout", dmout, 32'h0);
    op("sh11", 1'b1, 1'b0, 1'b1, WM_HU, 32'h11, 32'h0000_1234, 5'd5);
    op("lsw", 1'b1, 1'b1, 1'b1, WM_WD, 32'h13, 32'h0, 5'd5);
    lw("lw10d", 32'h10, 32'hBEEF_3344);

    // Range boundaries
    op("sw_top", 1'b1, 1'b0, 1'b1, WM_WD, 32'h0000_4000, 32'hDEAD_BEEF, 5'd5);
    op("lw_neg", 1'b1, 1'b1, 1'b0, WM_WD, 32'hFFFF_FFFC, 32'h0, 5'd4);
    chk("lw_neg.dmout", dmout, 32'h0);
    lw("lw0", 32'h0, 32'h0);
    op("sw_last", 1'b1, 1'b0, 1'b1, WM_WD, 32'h0000_3FFC, 32'hCAFE_F00D, 5'd0);
    lw("lw_last", 32'h0000_3FFC, 32'hCAFE_F00D);

    // Invalid size: no fault, no write, load still captures
    op("sw_bad", 1'b1, 1'b0, 1'b1, WM_BAD, 32'h11, 32'h0, 5'd0);
    op("lw_bad", 1'b1, 1'b1, 1'b0, WM_BAD, 32'h10, 32'h0, 5'd0);
    chk("lw_bad.dmout", dmout, 32'hBEEF_3344);

    // Hold freezes registers and memory; exceptions still track
    lw("lw10e", 32'h10, 32'hBEEF_3344);
    hold = 1'b1;
    op("hold_sw", 1'b1, 1'b0, 1'b1, WM_WD, 32'h20, 32'h5566_7788, 5'd0);
    chk("hold_sw.dmout", dmout, 32'hBEEF_3344);
    chk("hold_sw.ao_w", ao_w, 32'h10);
    op("hold_lw", 1'b1, 1'b1, 1'b0, WM_WD, 32'h21, 32'h0, 5'd4);
    chk("hold_lw.dmout", dmout, 32'hBEEF_3344);
    chk("hold_lw.ao_w", ao_w, 32'h10);
    hold = 1'b0;
    lw("lw20a", 32'h20, 32'h0);
    op("sw20", 1'b1, 1'b0, 1'b1, WM_WD, 32'h20, 32'h1234_5678, 5'd0);
    lw("lw20b", 32'h20, 32'h1234_5678);

    // Reset wins over a simultaneous store and clears memory
    reset = 1'b1;
    op("rst_sw", 1'b1, 1'b0, 1'b1, WM_WD, 32'h30, 32'hDEAD_0001, 5'd0);
    chk("rst.dmout", dmout, 32'h0);
    chk("rst.ao_w", ao_w, 32'h0);
    reset = 1'b0;
    lw("post10", 32'h10, 32'h0);
    lw("post20", 32'h20, 32'h0);
    lw("post30", 32'h30, 32'h0);
    lw("postlast", 32'h0000_3FFC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
